// File: rtl/pingpong_bank_ctrl_pkg.sv
// pingpong_bank_ctrl_pkg: bank indices and default geometry shared by the
// ping-pong controller and the buffer RAM beside it.
package pingpong_bank_ctrl_pkg;
   localparam int BANK_DEPTH_DEF = 1024;
   localparam int ADDR_W_DEF = $clog2(BANK_DEPTH_DEF);
   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;
endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// pingpong_bank_ctrl_if: producer/consumer handshake and RAM addressing bus.
interface pingpong_bank_ctrl_if import pingpong_bank_ctrl_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic wr_req;
   logic wr_close;
   logic wr_ready;
   logic wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic wr_last;
   logic rd_req;
   logic rd_valid;
   logic rd_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic rd_last;
   logic [1:0] bank_full;
   modport master (
      output wr_req, wr_close, rd_req,
      input wr_ready, wr_bank, wr_addr, wr_last,
      input rd_valid, rd_bank, rd_addr, rd_last, bank_full
   );
   modport slave (
      input wr_req, wr_close, rd_req,
      output wr_ready, wr_bank, wr_addr, wr_last,
      output rd_valid, rd_bank, rd_addr, rd_last, bank_full
   );
endinterface

// File: rtl/pingpong_bank_ctrl_side_counter.sv
// pp_side_counter: word address counter with terminal compare; clear wins over increment.
module pp_side_counter import pingpong_bank_ctrl_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic [ADDR_W-1:0] last,
   output logic [ADDR_W-1:0] cnt,
   output logic term
);
   assign term = cnt == last;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= clr ? '0 : cnt + ADDR_W'(inc);
endmodule

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: sequences bank ownership, fill/drain addresses and
// per-bank frame length between one producer and one consumer.
module pingpong_bank_ctrl import pingpong_bank_ctrl_pkg::*; #(
   parameter int BANK_DEPTH = BANK_DEPTH_DEF,
   parameter int ADDR_W = $clog2(BANK_DEPTH)
) (
   input logic clk,
   input logic rst,
   pingpong_bank_ctrl_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(BANK_DEPTH - 1);
   logic [1:0] full;
   logic wb, rb;
   logic [ADDR_W-1:0] wcnt, rcnt, rlast_idx;
   logic [ADDR_W:0] len0, len1, rlen, wlen;
   logic wterm, rterm, fire_w, fire_r, close_w, close_idle, close_any, rel;
   assign fire_w = bus.wr_req & ~full[wb];
   assign close_w = fire_w & (wterm | bus.wr_close);
   // a bare close publishes what is already written; an empty frame is never published
   assign close_idle = bus.wr_close & ~fire_w & (wcnt != '0) & ~full[wb];
   assign close_any = close_w | close_idle;
   assign wlen = {1'b0, wcnt} + (ADDR_W+1)'(fire_w);
   assign rlen = (rb == BANK1) ? len1 : len0;
   assign rlast_idx = ADDR_W'(rlen - 1'b1);
   assign fire_r = bus.rd_req & full[rb];
   assign rel = fire_r & rterm;
   pp_side_counter #(.ADDR_W(ADDR_W)) u_wcnt (
      .clk(clk), .rst(rst), .clr(close_any), .inc(fire_w),
      .last(LAST_W), .cnt(wcnt), .term(wterm)
   );
   pp_side_counter #(.ADDR_W(ADDR_W)) u_rcnt (
      .clk(clk), .rst(rst), .clr(rel), .inc(fire_r),
      .last(rlast_idx), .cnt(rcnt), .term(rterm)
   );
   // close and release always target different banks, so both may land together
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         full <= '0;
         wb <= BANK0;
         rb <= BANK0;
         len0 <= '0;
         len1 <= '0;
      end else begin
         if (close_any) begin
            full[wb] <= 1'b1;
            wb <= ~wb;
            if (wb == BANK1) len1 <= wlen;
            else len0 <= wlen;
         end
         if (rel) begin
            full[rb] <= 1'b0;
            rb <= ~rb;
         end
      end
   assign bus.wr_ready = ~full[wb];
   assign bus.wr_bank = wb;
   assign bus.wr_addr = wcnt;
   assign bus.wr_last = close_w;
   assign bus.rd_valid = full[rb];
   assign bus.rd_bank = rb;
   assign bus.rd_addr = rcnt;
   assign bus.rd_last = full[rb] & rterm;
   assign bus.bank_full = full;
endmodule
